mlp_layer_sequencer: RTL

- Parametrised successor to the fixed 16-4-4-1 MLP control unit.
- Walks every layer, every output neuron and every fan-in weight to drive the input-neuron RAM, the weight RAM and the neuron write-back.
- Layer sizes are loaded at run time.
- Adds a start/busy/done handshake, a stall input, a linear packed weight address and a config error flag. It sits between the top-level host FSM and the MAC/neuron memories.

---
 rtl/mlp_layer_sequencer_pkg.sv | 23 ++
 rtl/mlp_layer_sequencer_nested_counter.sv | 65 ++++++
 rtl/mlp_layer_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mlp_layer_sequencer_pkg.sv
// Shared types and defaults for the MLP layer sequencer, neuron RAM and MAC blocks.
package mlp_pkg;

  localparam int MLP_NUM_LAYERS = 4;
  localparam int MLP_CNT_W      = 8;
  localparam int MLP_LAYER_W    = 2;
  localparam int MLP_WADDR_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } seq_state_e;

  // Neuron RAM address is {layer, index}; callers cast down to LAYER_W+CNT_W.
  function automatic logic [31:0] pack_addr(input logic [31:0] layer,
                                            input logic [31:0] idx,
                                            input int          cnt_w);
    return (layer << cnt_w) | idx;
  endfunction

endpackage

// File: rtl/mlp_layer_sequencer_nested_counter.sv
// Cascaded weight/neuron/layer counters with wrap flags; MLP_SEQ_BIAS_EN adds one bias slot per neuron.
module mlp_nested_counter
  import mlp_pkg::*;
#(
  parameter int NUM_LAYERS = MLP_NUM_LAYERS,
  parameter int CNT_W      = MLP_CNT_W,
  parameter int LAYER_W    = MLP_LAYER_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        step,
  input  logic [NUM_LAYERS*CNT_W-1:0] sizes,
  output logic [LAYER_W-1:0]          layer,
  output logic [CNT_W-1:0]            neuron,
  output logic [CNT_W-1:0]            weight,
  output logic                        w_wrap,
  output logic                        n_wrap,
  output logic                        last_step,
  output logic                        bias
);

  logic [CNT_W-1:0] fan_in;
  logic [CNT_W-1:0] fan_out;

  always_comb begin
    fan_in  = '0;
    fan_out = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (i == int'(layer))     fan_in  = sizes[i*CNT_W +: CNT_W];
      if (i == int'(layer) + 1) fan_out = sizes[i*CNT_W +: CNT_W];
    end
  end

`ifdef MLP_SEQ_BIAS_EN
  assign bias   = (weight == fan_in);
  assign w_wrap = bias;
`else
  assign bias   = 1'b0;
  assign w_wrap = (weight == fan_in - CNT_W'(1));
`endif
  assign n_wrap    = (neuron == fan_out - CNT_W'(1));
  assign last_step = w_wrap && n_wrap && (layer == LAYER_W'(NUM_LAYERS - 2));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      layer  <= '0;
      neuron <= '0;
      weight <= '0;
    end else if (step) begin
      if (!w_wrap) begin
        weight <= weight + CNT_W'(1);
      end else begin
        weight <= '0;
        if (!n_wrap) begin
          neuron <= neuron + CNT_W'(1);
        end else begin
          neuron <= '0;
          layer  <= last_step ? '0 : layer + LAYER_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// MLP layer sequencer: walks layer/neuron/weight, drives MAC addresses and neuron write-back.
// Optional per-neuron bias step when MLP_SEQ_BIAS_EN is defined.
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int NUM_LAYERS = MLP_NUM_LAYERS,
  parameter int CNT_W      = MLP_CNT_W,
  parameter int LAYER_W    = MLP_LAYER_W,
  parameter int WADDR_W    = MLP_WADDR_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_LAYERS*CNT_W-1:0] layer_sizes,
  input  logic                        step_en,
  output logic                        busy,
  output logic [LAYER_W+CNT_W-1:0]    in_addr,
  output logic [WADDR_W-1:0]          weight_addr,
  output logic                        mac_valid,
  output logic                        acc_clear,
  output logic [LAYER_W+CNT_W-1:0]    out_addr,
  output logic                        write_neuron,
  output logic                        done,
`ifdef MLP_SEQ_BIAS_EN
  output logic                        bias_step,
`endif
  output logic                        cfg_err
);

  seq_state_e state, state_next;

  logic [NUM_LAYERS*CNT_W-1:0] sizes_q;
  logic                        err_q;
  logic                        size_zero;
  logic [WADDR_W-1:0]          waddr_cnt;
  logic                        last_q, last_d;
  logic [LAYER_W-1:0]          lq_layer;
  logic [CNT_W-1:0]            lq_neuron;

  logic [LAYER_W-1:0] layer;
  logic [CNT_W-1:0]   neuron, weight;
  logic               w_wrap, n_wrap, last_step, bias;
  logic               step;

  logic                     busy_d, mac_valid_d, acc_clear_d, write_d, done_d, cfg_err_d;
  logic [LAYER_W+CNT_W-1:0] in_addr_d, out_addr_d;
  logic [WADDR_W-1:0]       weight_addr_d;
`ifdef MLP_SEQ_BIAS_EN
  logic                     bias_d;
`endif

  assign step = (state == RUN) && step_en;

  mlp_nested_counter #(
    .NUM_LAYERS (NUM_LAYERS),
    .CNT_W      (CNT_W),
    .LAYER_W    (LAYER_W)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (state != RUN),
    .step      (step),
    .sizes     (sizes_q),
    .layer     (layer),
    .neuron    (neuron),
    .weight    (weight),
    .w_wrap    (w_wrap),
    .n_wrap    (n_wrap),
    .last_step (last_step),
    .bias      (bias)
  );

  always_comb begin
    size_zero = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (layer_sizes[i*CNT_W +: CNT_W] == '0) size_zero = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sizes_q   <= '0;
      err_q     <= 1'b0;
      waddr_cnt <= '0;
      last_q    <= 1'b0;
      lq_layer  <= '0;
      lq_neuron <= '0;
    end else begin
      state  <= state_next;
      last_q <= last_d;
      if (last_d) begin
        lq_layer  <= layer;
        lq_neuron <= neuron;
      end
      if (state == IDLE && start) begin
        sizes_q   <= layer_sizes;
        err_q     <= size_zero;
        waddr_cnt <= '0;
      end else if (step) begin
        waddr_cnt <= waddr_cnt + WADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = size_zero ? FIN : RUN;
      RUN:     if (step_en && last_step) state_next = FLUSH;
      FLUSH:   state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write-back trails the presented last-weight (or bias) step by one cycle, independent of stalls.
  always_comb begin
    busy_d        = 1'b0;
    mac_valid_d   = 1'b0;
    acc_clear_d   = 1'b0;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;
    last_d        = 1'b0;
    write_d       = last_q;
    in_addr_d     = in_addr;
    weight_addr_d = weight_addr;
`ifdef MLP_SEQ_BIAS_EN
    bias_d        = 1'b0;
`endif
    out_addr_d    = last_q ? (LAYER_W+CNT_W)'(pack_addr(32'(lq_layer) + 32'd1, 32'(lq_neuron), CNT_W))
                           : out_addr;
    unique case (state)
      IDLE:  busy_d = start && !size_zero;
      RUN: begin
        busy_d = 1'b1;
        if (step_en) begin
          mac_valid_d   = 1'b1;
          acc_clear_d   = (weight == '0);
          weight_addr_d = waddr_cnt;
          last_d        = w_wrap;
`ifdef MLP_SEQ_BIAS_EN
          bias_d        = bias;
`endif
          if (!bias) in_addr_d = (LAYER_W+CNT_W)'(pack_addr(32'(layer), 32'(weight), CNT_W));
        end
      end
      FLUSH: busy_d = 1'b1;
      FIN: begin
        done_d    = 1'b1;
        cfg_err_d = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy         <= 1'b0;
      in_addr      <= '0;
      weight_addr  <= '0;
      mac_valid    <= 1'b0;
      acc_clear    <= 1'b0;
      out_addr     <= '0;
      write_neuron <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
`ifdef MLP_SEQ_BIAS_EN
      bias_step    <= 1'b0;
`endif
    end else begin
      busy         <= busy_d;
      in_addr      <= in_addr_d;
      weight_addr  <= weight_addr_d;
      mac_valid    <= mac_valid_d;
      acc_clear    <= acc_clear_d;
      out_addr     <= out_addr_d;
      write_neuron <= write_d;
      done         <= done_d;
      cfg_err      <= cfg_err_d;
`ifdef MLP_SEQ_BIAS_EN
      bias_step    <= bias_d;
`endif
    end
  end

endmodule
